// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Stall / bubble / flush producer for the 5-stage pipeline.
//                Detects load-use hazards, data-memory wait states and
//                multi-cycle divides, resolves taken-branch flushes, and
//                keeps a saturating stall-cycle counter plus a sticky
//                memory-timeout error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
  parameter int DIV_LAT     = 8,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic             ex_div_start,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_all,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  // One shared counter serves both wait states; size it for the larger bound.
  localparam int C_MAXC = (MEM_TIMEOUT > DIV_LAT) ? MEM_TIMEOUT : DIV_LAT;
  localparam int C_TW   = $clog2(C_MAXC + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [C_TW-1:0]  cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic w_load_use;
  logic w_stall_all;
  logic w_resolve;
  logic w_flush;
  logic w_bubble;

  assign w_load_use = ex_valid & ex_is_load & (ex_rd != 5'd0) &
                      ((id_rs1_used & (id_rs1 == ex_rd)) |
                       (id_rs2_used & (id_rs2 == ex_rd)));

  // Next-state logic; w_resolve marks cycles where EX advances and branch /
  // load-use resolution may act (including the exit cycle of a wait state).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_err_d   = mem_err_q;
    w_stall_all = 1'b0;
    w_resolve   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ack) begin
          w_stall_all = 1'b1;
          state_d     = ST_MEM_WAIT;
          cnt_d       = C_TW'(1);
        end else if (ex_valid && ex_div_start) begin
          w_stall_all = 1'b1;
          state_d     = ST_DIV_WAIT;
          cnt_d       = C_TW'(DIV_LAT - 2);
        end else begin
          w_resolve   = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          state_d     = ST_RUN;
          w_resolve   = 1'b1;
        end else if (cnt_q == C_TW'(MEM_TIMEOUT)) begin
          mem_err_d   = 1'b1;
          state_d     = ST_RUN;
          w_resolve   = 1'b1;
        end else begin
          w_stall_all = 1'b1;
          cnt_d       = cnt_q + C_TW'(1);
        end
      end
      ST_DIV_WAIT: begin
        if (cnt_q != '0) begin
          w_stall_all = 1'b1;
          cnt_d       = cnt_q - C_TW'(1);
        end else begin
          state_d     = ST_RUN;
          w_resolve   = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // A taken branch flushes the dependent instruction, so it wins over load-use.
  assign w_flush  = w_resolve & ex_br_taken;
  assign w_bubble = w_resolve & ~ex_br_taken & w_load_use;

  // Saturating performance counter of stalled or bubbled cycles.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((w_stall_all || w_bubble) && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  // State, counter, error flag and performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      cnt_q          <= '0;
      mem_err_q      <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mem_err_q      <= mem_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Controls are forced low during reset so nothing glitches on release.
  assign stall_all    = ~rst & w_stall_all;
  assign stall_if     = ~rst & (w_stall_all | w_bubble);
  assign stall_id     = ~rst & (w_stall_all | w_bubble);
  assign bubble_ex    = ~rst & w_bubble;
  assign flush_id     = ~rst & w_flush;
  assign flush_ex     = ~rst & w_flush;
  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_ctrl
//  Description : Self-checking bench for hazard_stall_ctrl: directed hazard
//                scenarios with literal expectations, then randomized traffic
//                compared every cycle against a cycle-count reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  localparam int  DIV_LAT = 8;
  localparam int  MEM_TO  = 4;
  localparam int  CNT_W   = 32;
  localparam int  CNT_WS  = 3;
  localparam longint C_MAX   = (64'sd1 <<< CNT_W) - 1;
  localparam longint C_MAX_S = (64'sd1 <<< CNT_WS) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_rs1_used = 0, id_rs2_used = 0, ex_valid = 0, ex_is_load = 0;
  logic       ex_div_start = 0, ex_br_taken = 0, mem_req = 0, mem_ack = 0;

  logic stall_if, stall_id, stall_all, bubble_ex, flush_id, flush_ex, mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic s_if, s_id, s_all, s_bub, s_fid, s_fex, s_err;
  logic [CNT_WS-1:0] stall_cycles_s;

  hazard_stall_ctrl #(.DIV_LAT(DIV_LAT), .MEM_TIMEOUT(MEM_TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_div_start(ex_div_start),
    .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_id(stall_id), .stall_all(stall_all),
    .bubble_ex(bubble_ex), .flush_id(flush_id), .flush_ex(flush_ex),
    .mem_err(mem_err), .stall_cycles(stall_cycles));

  // Narrow-counter copy used to exercise counter saturation.
  hazard_stall_ctrl #(.DIV_LAT(DIV_LAT), .MEM_TIMEOUT(MEM_TO), .CNT_W(CNT_WS)) dut_s (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_div_start(ex_div_start),
    .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .stall_if(s_if), .stall_id(s_id), .stall_all(s_all),
    .bubble_ex(s_bub), .flush_id(s_fid), .flush_ex(s_fex),
    .mem_err(s_err), .stall_cycles(stall_cycles_s));

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // busy: 0 = pipeline flowing, 1 = waiting on memory, 2 = dividing.
  // waited / frozen count cycles already spent stalled for the current event.
  int     m_busy   = 0;
  int     m_waited = 0;
  int     m_frozen = 0;
  bit     m_err    = 0;
  longint m_cnt    = 0;
  longint m_cnt_s  = 0;

  function automatic void model_out(output bit sa, output bit fl, output bit bub);
    bit lu, adv;
    lu  = ex_valid && ex_is_load && (ex_rd != 0) &&
          ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    sa  = 0;
    adv = 0;
    if (m_busy == 0) begin
      if (mem_req && !mem_ack)         sa  = 1;
      else if (ex_valid && ex_div_start) sa = 1;
      else                             adv = 1;
    end else if (m_busy == 1) begin
      if (mem_ack || m_waited >= MEM_TO) adv = 1;
      else                               sa  = 1;
    end else begin
      if (m_frozen >= DIV_LAT - 1) adv = 1;
      else                         sa  = 1;
    end
    fl  = adv && ex_br_taken;
    bub = adv && !ex_br_taken && lu;
    if (rst) begin
      sa = 0; fl = 0; bub = 0;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    bit sa, fl, bub;
    if (rst) begin
      m_busy = 0; m_waited = 0; m_frozen = 0; m_err = 0; m_cnt = 0; m_cnt_s = 0;
    end else begin
      model_out(sa, fl, bub);
      if (sa || bub) begin
        if (m_cnt   < C_MAX)   m_cnt++;
        if (m_cnt_s < C_MAX_S) m_cnt_s++;
      end
      case (m_busy)
        0: if (mem_req && !mem_ack) begin m_busy = 1; m_waited = 1; end
           else if (ex_valid && ex_div_start) begin m_busy = 2; m_frozen = 1; end
        1: if (mem_ack) m_busy = 0;
           else if (m_waited >= MEM_TO) begin m_busy = 0; m_err = 1; end
           else m_waited++;
        default: if (m_frozen >= DIV_LAT - 1) m_busy = 0; else m_frozen++;
      endcase
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    bit sa, fl, bub;
    model_out(sa, fl, bub);
    chk("stall_all",      stall_all,      sa);
    chk("stall_if",       stall_if,       sa | bub);
    chk("stall_id",       stall_id,       sa | bub);
    chk("bubble_ex",      bubble_ex,      bub);
    chk("flush_id",       flush_id,       fl);
    chk("flush_ex",       flush_ex,       fl);
    chk("mem_err",        mem_err,        m_err);
    chk("stall_cycles",   stall_cycles,   m_cnt);
    chk("stall_cycles_s", stall_cycles_s, m_cnt_s);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_valid = 0; ex_is_load = 0; ex_div_start = 0; ex_br_taken = 0;
    mem_req = 0; mem_ack = 0;
  endtask

  initial begin
    int n;
    clear_in();
    rst = 1;
    tick(); tick();
    #2;
    chk("rst_stall_all", stall_all, 0);
    chk("rst_counter",   stall_cycles, 0);
    chk("rst_mem_err",   mem_err, 0);
    tick();
    rst = 0;
    tick();

    // Load-use on rs1: exactly one bubble.
    ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
    #2;
    chk("lu_bubble",   bubble_ex, 1);
    chk("lu_stall_if", stall_if, 1);
    chk("lu_stall_id", stall_id, 1);
    tick();
    ex_valid = 0; ex_is_load = 0;
    #2;
    chk("lu_one_bubble", bubble_ex, 0);
    chk("lu_count",      stall_cycles, 1);
    tick();

    // x0 destination and unused rs2 never stall.
    ex_valid = 1; ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1;
    #2;
    chk("x0_no_bubble", bubble_ex, 0);
    tick();
    ex_rd = 7; id_rs1 = 3; id_rs2 = 7; id_rs2_used = 0;
    #2;
    chk("unused_rs2_no_bubble", bubble_ex, 0);
    tick();
    clear_in();

    // Memory wait: three ack-less cycles, then ack.
    mem_req = 1;
    n = 0;
    repeat (3) begin #2; if (stall_all) n++; tick(); end
    mem_ack = 1;
    #2;
    chk("memwait_ack_cycle", stall_all, 0);
    chk("memwait_stalls",    n, 3);
    tick();
    clear_in();
    #2;
    chk("memwait_back_run", stall_all, 0);
    tick();

    // Timeout: no ack ever.
    mem_req = 1;
    n = 0;
    repeat (5) begin #2; if (stall_all) n++; tick(); end
    chk("timeout_stalls", n, 4);
    mem_req = 0;
    #2;
    chk("timeout_err",       mem_err, 1);
    chk("timeout_stall_off", stall_all, 0);
    repeat (3) tick();
    #2;
    chk("timeout_sticky", mem_err, 1);
    chk("count_after_mem", stall_cycles, 8);
    tick();

    // Divide: seven frozen cycles.
    ex_valid = 1; ex_div_start = 1;
    n = 0;
    repeat (8) begin #2; if (stall_all) n++; tick(); end
    chk("div_stalls", n, 7);
    clear_in();
    #2;
    chk("count_after_div", stall_cycles, 15);
    tick();

    // Branch and load-use in the same cycle: flush wins.
    ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1; ex_br_taken = 1;
    #2;
    chk("br_flush_id", flush_id, 1);
    chk("br_flush_ex", flush_ex, 1);
    chk("br_no_bubble", bubble_ex, 0);
    tick();
    clear_in();

    // Reset in the middle of a divide.
    ex_valid = 1; ex_div_start = 1;
    tick(); tick(); tick();
    rst = 1;
    #2;
    chk("rst_div_stall_all", stall_all, 0);
    chk("rst_div_stall_if",  stall_if, 0);
    tick();
    rst = 0;
    clear_in();
    #2;
    chk("rst_div_released", stall_all, 0);
    chk("rst_div_count",    stall_cycles, 0);
    tick();

    // Randomized traffic.
    repeat (4000) begin
      rst          = ($urandom_range(0, 399) == 0);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      id_rs1_used  = $urandom_range(0, 3) != 0;
      id_rs2_used  = $urandom_range(0, 1) != 0;
      ex_valid     = $urandom_range(0, 3) != 0;
      ex_is_load   = $urandom_range(0, 2) == 0;
      ex_div_start = $urandom_range(0, 15) == 0;
      ex_br_taken  = $urandom_range(0, 7) == 0;
      mem_req      = $urandom_range(0, 4) == 0;
      mem_ack      = $urandom_range(0, 1) == 0;
      tick();
    end
    rst = 0;
    clear_in();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
`default_nettype wire
